// File: rtl/psum_ofifo.sv
// Output-side collector for the systolic array: one FIFO per column absorbs
// skewed south-edge partial sums and releases complete, column-aligned rows.
module psum_ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   out_vld,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   overflow
);

   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;

   logic [psum_bw-1:0] mem [col][depth];
   logic [aw-1:0]      wp  [col];
   logic [aw-1:0]      rp  [col];
   logic [cw-1:0]      cnt [col];

   logic [col-1:0] full;
   logic [col-1:0] wr_acc;
   logic [col-1:0] wr_drop;
   logic           rd_acc;

   always_comb begin
      o_valid = 1'b1;
      o_full  = 1'b0;
      for (int c = 0; c < col; c++) begin
         full[c] = (cnt[c] == cw'(depth));
         o_valid = o_valid & (cnt[c] != '0);
         o_full  = o_full | full[c];
      end
      o_ready = ~o_full;
      rd_acc  = rd & o_valid;
      // A full column can still take a write when a row pop frees a slot this cycle.
      wr_acc  = wr & (~full | {col{rd_acc}});
      wr_drop = wr & full & {col{~rd_acc}};
   end

   // NOTE: storage is deliberately outside the reset domain; pointers and counts
   // alone define validity, so the array maps onto plain RAM without reset logic.
   always_ff @(posedge clk) begin
      for (int c = 0; c < col; c++) begin
         if (wr_acc[c]) mem[c][wp[c]] <= in[psum_bw*c +: psum_bw];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < col; c++) begin
            wp[c]  <= '0;
            rp[c]  <= '0;
            cnt[c] <= '0;
         end
         out      <= '0;
         out_vld  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         out_vld <= rd_acc;
         if (|wr_drop) overflow <= 1'b1;
         for (int c = 0; c < col; c++) begin
            if (wr_acc[c]) wp[c] <= wp[c] + aw'(1);
            if (rd_acc) begin
               rp[c] <= rp[c] + aw'(1);
               out[psum_bw*c +: psum_bw] <= mem[c][rp[c]];
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (wr_acc[c] && !rd_acc)      cnt[c] <= cnt[c] + cw'(1);
            else if (!wr_acc[c] && rd_acc) cnt[c] <= cnt[c] - cw'(1);
         end
      end
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: a queue-per-column model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_psum_ofifo;

   localparam int COL   = 8;
   localparam int PSW   = 16;
   localparam int DEPTH = 64;
   localparam int W     = COL * PSW;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [W-1:0]   in = '0;
   logic [COL-1:0] wr = '0;
   logic           rd = 1'b0;
   logic [W-1:0]   out;
   logic           out_vld, o_valid, o_full, o_ready, overflow;

   int vectors = 0;
   int miscompares = 0;

   psum_ofifo #(.col(COL), .psum_bw(PSW), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
      .out(out), .out_vld(out_vld), .o_valid(o_valid),
      .o_full(o_full), .o_ready(o_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [PSW-1:0] q [COL][$];
   logic [PSW-1:0] m_out [COL];
   logic           m_vld, m_ovf;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < COL; c++) begin
            q[c].delete();
            m_out[c] = '0;
         end
         m_vld = 1'b0;
         m_ovf = 1'b0;
      end else begin
         bit row_ready;
         row_ready = 1'b1;
         for (int c = 0; c < COL; c++) if (q[c].size() == 0) row_ready = 1'b0;
         m_vld = rd && row_ready;
         if (m_vld) for (int c = 0; c < COL; c++) m_out[c] = q[c].pop_front();
         for (int c = 0; c < COL; c++) begin
            if (wr[c]) begin
               if (q[c].size() < DEPTH) q[c].push_back(in[PSW*c +: PSW]);
               else m_ovf = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] e_out;
      logic e_valid, e_full;
      e_valid = 1'b1;
      e_full  = 1'b0;
      for (int c = 0; c < COL; c++) begin
         e_out[PSW*c +: PSW] = m_out[c];
         if (q[c].size() == 0) e_valid = 1'b0;
         if (q[c].size() == DEPTH) e_full = 1'b1;
      end
      check("m.out", out, e_out);
      check("m.out_vld", W'(out_vld), W'(m_vld));
      check("m.o_valid", W'(o_valid), W'(e_valid));
      check("m.o_full", W'(o_full), W'(e_full));
      check("m.o_ready", W'(o_ready), W'(!e_full));
      check("m.overflow", W'(overflow), W'(m_ovf));
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [W-1:0] row(input logic [PSW-1:0] v);
      return {COL{v}};
   endfunction

   // Apply one cycle of inputs; returns 2 time units after the active edge.
   task automatic drive(input logic [COL-1:0] w, input logic r, input logic [W-1:0] d);
      wr = w;
      rd = r;
      in = d;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      wr = '0; rd = 1'b0; in = '0;
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic [W-1:0] d;

      // Reset then idle, with rd held high
      @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive('0, 1'b1, '0);
         check("idle.out", out, '0);
         check("idle.out_vld", W'(out_vld), W'(0));
         check("idle.o_valid", W'(o_valid), W'(0));
         check("idle.o_ready", W'(o_ready), W'(1));
         check("idle.overflow", W'(overflow), W'(0));
      end

      // Skewed fill: column c written at cycle c
      for (int c = 0; c < COL; c++) begin
         d = '0;
         d[PSW*c +: PSW] = 16'h0100 + PSW'(c);
         drive(COL'(1) << c, 1'b0, d);
         check("skew.o_valid", W'(o_valid), W'(c == COL - 1));
      end
      drive('0, 1'b1, '0);
      check("skew.out", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      check("skew.out_vld", W'(out_vld), W'(1));
      drive('0, 1'b0, '0);
      check("skew.out_vld_drop", W'(out_vld), W'(0));
      check("skew.out_hold", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

      // Streaming: write every column every cycle while reading continuously
      for (int r = 0; r < 200; r++) begin
         drive('1, 1'b1, row(16'h1000 + PSW'(r)));
         if (r > 0) begin
            check("stream.out", out, row(16'h1000 + PSW'(r - 1)));
            check("stream.out_vld", W'(out_vld), W'(1));
         end
      end
      drive('0, 1'b1, '0);
      check("stream.last", out, row(16'h10C7));
      check("stream.overflow", W'(overflow), W'(0));
      check("stream.empty", W'(o_valid), W'(0));

      // Full boundary on column 3
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         d = '0;
         d[PSW*3 +: PSW] = PSW'(i);
         drive(8'h08, 1'b0, d);
         check("full.o_full", W'(o_full), W'(i == DEPTH - 1));
      end
      check("full.o_ready", W'(o_ready), W'(0));
      check("full.no_ovf", W'(overflow), W'(0));
      drive(8'h08, 1'b0, '1);
      check("full.overflow", W'(overflow), W'(1));
      check("full.still_full", W'(o_full), W'(1));

      // Full plus simultaneous pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) drive('1, 1'b0, row(16'h2000 + PSW'(i)));
      check("fpop.o_full", W'(o_full), W'(1));
      drive('1, 1'b1, row(16'h3000));
      check("fpop.out", out, row(16'h2000));
      check("fpop.o_full_kept", W'(o_full), W'(1));
      check("fpop.overflow", W'(overflow), W'(0));
      for (int i = 0; i < DEPTH; i++) drive('0, 1'b1, '0);
      check("fpop.tail", out, row(16'h3000));
      check("fpop.drained", W'(o_valid), W'(0));

      // Reset mid-stream with 10 rows buffered
      do_reset();
      for (int i = 0; i < 11; i++) drive('1, 1'b0, row(16'h4000 + PSW'(i)));
      drive('0, 1'b1, '0);
      check("rst.pre_out", out, row(16'h4000));
      #1;
      reset = 1'b1;
      #1;
      check("rst.out", out, '0);
      check("rst.out_vld", W'(out_vld), W'(0));
      check("rst.o_valid", W'(o_valid), W'(0));
      check("rst.o_ready", W'(o_ready), W'(1));
      check("rst.overflow", W'(overflow), W'(0));
      @(posedge clk);
      #2;
      reset = 1'b0;
      drive('1, 1'b0, 128'h5007_5006_5005_5004_5003_5002_5001_5000);
      drive('1, 1'b1, row(16'h6000));
      check("rst.first_row", out, 128'h5007_5006_5005_5004_5003_5002_5001_5000);
      drive('0, 1'b0, '0);
      drive('0, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output-side collector for the systolic `mac_array`: captures the per-column partial sums that emerge skewed in time on `out_s`, qualified by the per-column `valid` bits. It buffers them in one FIFO per column and releases complete, column-aligned rows to downstream logic (SRAM writeback / accumulator). It is the receiving end of the array's south-edge output protocol, and its backpressure flag lets the controller stall instruction issue.

## Interface

Parameters:
- `col`, 8, number of array columns / FIFO lanes.
- `psum_bw`, 16, partial-sum width per column.
- `depth`, 64, entries per column FIFO; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in`  in  psum_bw*col  psum bus from `mac_array.out_s`; column c at bits [psum_bw*(c+1)-1 : psum_bw*c].
- `wr`  in  col  per-column write strobes from `mac_array.valid`.
- `rd`  in  1  row read request.
- `out`  out  psum_bw*col  registered output row, same column packing as `in`.
- `out_vld`  out  1  one-cycle pulse marking a new row on `out`.
- `o_valid`  out  1  every column FIFO is non-empty, so a full row is available.
- `o_full`  out  1  at least one column FIFO is full.
- `o_ready`  out  1  equals `~o_full`; stall hint to the array controller.
- `overflow`  out  1  sticky: a write strobe was dropped.

## Operation

- Per column: storage of `depth` x `psum_bw`, write pointer and read pointer (log2(depth) bits each, wrap modulo `depth`), and an occupancy count (log2(depth)+1 bits, range 0..depth).
- Column c empty when count==0, full when count==depth.
- Read acceptance: `rd_acc = rd & o_valid`. `rd` while `o_valid`=0 is ignored, with no state change.
- On `rd_acc`: every column pops one entry. `out` loads the head entry of every column, and `out_vld`=1 for the following cycle.
- Write acceptance for column c: `wr[c] & (count_c < depth | rd_acc)`. A write to a full column is accepted only when a row pop happens in the same cycle.
- A write strobe to a full column without `rd_acc` is dropped, data is discarded and `overflow` sets. `overflow` clears only on reset.
- Simultaneous accepted write and pop on column c: count unchanged, both pointers advance.
- Columns are written independently and in any order (skewed arrival). Rows stay aligned because each column is strictly FIFO.
- `o_valid` = AND of all column non-empty flags. `o_full` = OR of all column full flags. Both are combinational from the counts.
- Reset: all pointers and counts 0, `out`=0, `out_vld`=0, `overflow`=0. So `o_valid`=0, `o_full`=0 and `o_ready`=1. Storage contents are undefined and are not reset.
- Reset asserted mid-operation discards all buffered data immediately (asynchronous). After release the block behaves as freshly reset.

## Timing

- Write to pop-visibility: if `wr[c]` is accepted at edge N, column c counts as non-empty from just after edge N. `o_valid` can therefore rise in the cycle after the last missing column is written.
- Read latency: if `rd_acc` is true before edge N, `out`/`out_vld` update at edge N. `out_vld` lasts exactly one cycle unless `rd_acc` is held.
- Back-to-back reads: `rd` held high pops one row per cycle while `o_valid` stays 1. `out_vld` stays high across consecutive accepted cycles.
- `out` holds its last value when there is no pop.
- `o_full`/`o_ready` reflect counts after the most recent edge. The controller must sample `o_ready` before issuing and is allowed one cycle of in-flight writes. Any write beyond capacity is dropped and flagged.

## Test plan

- Reset then idle: `out`=0, `out_vld`=0, `o_valid`=0, `o_ready`=1, `overflow`=0 for 10 cycles. `rd`=1 during idle produces no `out_vld`.
- Skewed fill: write column c with value 0x0100+c at cycle c (c=0..7), then `rd`=1 once. `o_valid` rises only after column 7 is written. One cycle after the pop, `out`={0x0107,...,0x0100} and `out_vld` pulses once.
- Streaming: all columns written every cycle with a row-index-tagged value (0x1000+r) while `rd`=1 continuously for 200 cycles. Rows emerge in order with no loss, pointers wrap past 64 and `overflow` stays 0.
- Full boundary: write column 3 only, 64 times. `o_full`=1 and `o_ready`=0 after the 64th write. A 65th write sets `overflow`=1 and column 3 count stays 64.
- Full plus simultaneous pop: fill all columns to 64, then assert `rd`=1 with `wr`=8'hFF on the same cycle. The write is accepted, counts stay 64, `overflow` stays 0, and the popped row is the oldest entries.
- Reset mid-stream: assert `reset` asynchronously with 10 rows buffered. Outputs return immediately to reset values. After release, the first row written is the first row read.
